// File: rtl/fb_rect_filler.sv
// fb_rect_filler: solid-colour rectangle rasteriser, two horizontally adjacent pixels per cycle, held off while vsync is low.
// Define FB_RECT_CLIP_EN to clip rectangles to the screen; otherwise off-screen slots past the framebuffer end are masked.
module fb_rect_filler #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               vsync,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [9:0]         cmd_x,
    input  logic [8:0]         cmd_y,
    input  logic [10:0]        cmd_w,
    input  logic [9:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic [ADDR_W-1:0]  addr_wr1,
    output logic [ADDR_W-1:0]  addr_wr2,
    output logic [COLOR_W-1:0] data_wr1,
    output logic [COLOR_W-1:0] data_wr2,
    output logic               wr1_en,
    output logic               wr2_en,
    output logic               busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    // Two spare bits so unclipped rectangles running off the bottom never wrap into valid addresses
    localparam int FW = ADDR_W + 2;

    logic [1:0]         state, state_n;
    logic [9:0]         x_q;
    logic [8:0]         y_q;
    logic [10:0]        w_q;
    logic [9:0]         h_q;
    logic [COLOR_W-1:0] color_q;
    logic [11:0]        x_end, col, x_sum, x_lim, col1, col2;
    logic [10:0]        y_end, row, y_sum, y_lim;
    logic [FW-1:0]      base, base_init, a1, a2;
    logic               empty, en1_n, en2_n, step, row_done, last_row, accept;

    assign x_sum     = {2'b0, x_q} + {1'b0, w_q};
    assign y_sum     = {2'b0, y_q} + {1'b0, h_q};
    assign base_init = (FW'(y_q) << 9) + (FW'(y_q) << 7);
    assign a1        = base + FW'(col);
    assign a2        = a1 + FW'(1);
    assign col1      = col + 12'd1;
    assign col2      = col + 12'd2;
    assign row_done  = col2 >= x_end;
    assign last_row  = row + 11'd1 >= y_end;
    assign step      = state == S_RUN && vsync;
    assign accept    = state == S_IDLE && cmd_valid && cmd_ready;

`ifdef FB_RECT_CLIP_EN
    localparam logic [11:0] W12 = 12'(WIDTH);
    localparam logic [10:0] H11 = 11'(HEIGHT);
    assign x_lim = x_sum > W12 ? W12 : x_sum;
    assign y_lim = y_sum > H11 ? H11 : y_sum;
    assign empty = {2'b0, x_q} >= W12 || {2'b0, y_q} >= H11 || w_q == '0 || h_q == '0;
    assign en1_n = 1'b1;
    assign en2_n = col1 < x_end;
`else
    localparam logic [FW-1:0] LIMIT = FW'(WIDTH * HEIGHT);
    assign x_lim = x_sum;
    assign y_lim = y_sum;
    assign empty = w_q == '0 || h_q == '0;
    assign en1_n = a1 < LIMIT;
    assign en2_n = col1 < x_end && a2 < LIMIT;
`endif

    always_comb begin
        state_n = state == S_IDLE  ? (accept ? S_SETUP : S_IDLE) :
                  state == S_SETUP ? (empty ? S_IDLE : S_RUN) :
                  state == S_RUN   ? (step && row_done && last_row ? S_IDLE : S_RUN) : S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            wr1_en    <= 1'b0;
            wr2_en    <= 1'b0;
            addr_wr1  <= '0;
            addr_wr2  <= '0;
            data_wr1  <= '0;
            data_wr2  <= '0;
        end else begin
            state     <= state_n;
            cmd_ready <= state_n == S_IDLE;
            busy      <= state_n != S_IDLE;
            wr1_en    <= step && en1_n;
            wr2_en    <= step && en2_n;
            if (step && en1_n) begin
                addr_wr1 <= a1[ADDR_W-1:0];
                data_wr1 <= color_q;
            end
            if (step && en2_n) begin
                addr_wr2 <= a2[ADDR_W-1:0];
                data_wr2 <= color_q;
            end
            if (accept) begin
                x_q     <= cmd_x;
                y_q     <= cmd_y;
                w_q     <= cmd_w;
                h_q     <= cmd_h;
                color_q <= cmd_color;
            end
            if (state == S_SETUP) begin
                x_end <= x_lim;
                y_end <= y_lim;
                base  <= base_init;
                col   <= {2'b0, x_q};
                row   <= {2'b0, y_q};
            end
            if (step) begin
                if (row_done) begin
                    col  <= {2'b0, x_q};
                    base <= base + FW'(WIDTH);
                    row  <= row + 11'd1;
                end else begin
                    col <= col2;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_rect_filler.sv
// tb_fb_rect_filler: directed checks of fb_rect_filler; drives on and samples at the falling edge.
module tb_fb_rect_filler;
    logic        clock = 1'b0, reset = 1'b0, vsync = 1'b1, cmd_valid = 1'b0;
    logic [9:0]  cmd_x = '0;
    logic [8:0]  cmd_y = '0;
    logic [10:0] cmd_w = '0;
    logic [9:0]  cmd_h = '0;
    logic [3:0]  cmd_color = '0;
    logic        cmd_ready, wr1_en, wr2_en, busy;
    logic [18:0] addr_wr1, addr_wr2;
    logic [3:0]  data_wr1, data_wr2;
    int tests = 0, fails = 0;

    fb_rect_filler dut (
        .clock(clock), .reset(reset), .vsync(vsync), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .addr_wr1(addr_wr1), .addr_wr2(addr_wr2), .data_wr1(data_wr1), .data_wr2(data_wr2),
        .wr1_en(wr1_en), .wr2_en(wr2_en), .busy(busy)
    );

    always #5 clock = ~clock;

    // Returns at the falling edge just after the accepting rising edge (engine in SETUP)
    task automatic issue(input int x, input int y, input int w, input int h, input logic [3:0] c);
        @(negedge clock);
        cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 11'(w); cmd_h = 10'(h); cmd_color = c;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        tests++;
        if ({cmd_ready, busy, wr1_en, wr2_en, addr_wr1, addr_wr2, data_wr1, data_wr2} !== '0) begin
            fails++;
            $display("FAIL reset_hold: ready=%b busy=%b en=%b%b a=%0d/%0d d=%h/%h, want all 0",
                     cmd_ready, busy, wr1_en, wr2_en, addr_wr1, addr_wr2, data_wr1, data_wr2);
        end
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready=%b busy=%b, want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic();
        int exp1 [4] = '{1290, 1292, 1930, 1932};
        issue(10, 2, 4, 2, 4'hA);
        tests++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_setup: busy=%b ready=%b, want 1 0", busy, cmd_ready);
        end
        @(negedge clock);
        tests++;
        if (wr1_en !== 1'b0 || wr2_en !== 1'b0) begin
            fails++;
            $display("FAIL basic_nowrite_setup: en=%b%b, want 00", wr1_en, wr2_en);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            tests++;
            if (wr1_en !== 1'b1 || wr2_en !== 1'b1 || addr_wr1 !== 19'(exp1[i]) ||
                addr_wr2 !== 19'(exp1[i] + 1) || data_wr1 !== 4'hA || data_wr2 !== 4'hA) begin
                fails++;
                $display("FAIL basic_write[%0d]: en=%b%b a=%0d/%0d d=%h/%h, want 11 %0d/%0d a/a",
                         i, wr1_en, wr2_en, addr_wr1, addr_wr2, data_wr1, data_wr2, exp1[i], exp1[i] + 1);
            end
        end
        @(negedge clock);
        tests++;
        if (wr1_en !== 1'b0 || wr2_en !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: en=%b%b ready=%b busy=%b, want 00 1 0", wr1_en, wr2_en, cmd_ready, busy);
        end
    endtask

    task automatic test_odd_width();
        issue(0, 0, 3, 1, 4'h5);
        repeat (2) @(negedge clock);
        tests++;
        if (wr1_en !== 1'b1 || wr2_en !== 1'b1 || addr_wr1 !== 19'd0 || addr_wr2 !== 19'd1 || data_wr2 !== 4'h5) begin
            fails++;
            $display("FAIL odd_first: en=%b%b a=%0d/%0d d2=%h, want 11 0/1 5", wr1_en, wr2_en, addr_wr1, addr_wr2, data_wr2);
        end
        @(negedge clock);
        tests++;
        if (wr1_en !== 1'b1 || wr2_en !== 1'b0 || addr_wr1 !== 19'd2 || addr_wr2 !== 19'd1) begin
            fails++;
            $display("FAIL odd_last: en=%b%b a=%0d/%0d, want 10 2/1", wr1_en, wr2_en, addr_wr1, addr_wr2);
        end
        @(negedge clock);
        tests++;
        if (wr1_en !== 1'b0 || wr2_en !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL odd_idle: en=%b%b ready=%b, want 00 1", wr1_en, wr2_en, cmd_ready);
        end
    endtask

    task automatic test_empty();
        int busy_cnt, en_cnt;
        issue(5, 5, 0, 7, 4'h3);
        busy_cnt = int'(busy);
        en_cnt = int'(wr1_en) + int'(wr2_en);
        repeat (4) begin
            @(negedge clock);
            busy_cnt += int'(busy);
            en_cnt += int'(wr1_en) + int'(wr2_en);
        end
        tests++;
        if (busy_cnt !== 1 || en_cnt !== 0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL empty: busy_cycles=%0d enables=%0d ready=%b, want 1 0 1", busy_cnt, en_cnt, cmd_ready);
        end
    endtask

    task automatic test_vsync_stall();
        int exp1 [4] = '{0, 2, 4, 6};
        issue(0, 0, 8, 1, 4'h7);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            tests++;
            if (wr1_en !== 1'b1 || wr2_en !== 1'b1 || addr_wr1 !== 19'(exp1[i]) || addr_wr2 !== 19'(exp1[i] + 1)) begin
                fails++;
                $display("FAIL vsync_write[%0d]: en=%b%b a=%0d/%0d, want 11 %0d/%0d",
                         i, wr1_en, wr2_en, addr_wr1, addr_wr2, exp1[i], exp1[i] + 1);
            end
            if (i == 1) begin
                vsync = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    tests++;
                    if (wr1_en !== 1'b0 || wr2_en !== 1'b0 || busy !== 1'b1) begin
                        fails++;
                        $display("FAIL vsync_stall[%0d]: en=%b%b busy=%b, want 00 1", k, wr1_en, wr2_en, busy);
                    end
                end
                vsync = 1'b1;
            end
        end
        @(negedge clock);
        tests++;
        if (wr1_en !== 1'b0 || wr2_en !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL vsync_done: en=%b%b ready=%b, want 00 1", wr1_en, wr2_en, cmd_ready);
        end
    endtask

    task automatic test_edge_clip();
        int n = 0, en_cnt = 0, n_exp;
`ifdef FB_RECT_CLIP_EN
        n_exp = 0;
`else
        n_exp = 11;
`endif
        issue(638, 479, 5, 4, 4'hC);
        repeat (2) @(negedge clock);
        tests++;
        if (wr1_en !== 1'b1 || wr2_en !== 1'b1 || addr_wr1 !== 19'd307198 || addr_wr2 !== 19'd307199) begin
            fails++;
            $display("FAIL edge_first: en=%b%b a=%0d/%0d, want 11 307198/307199", wr1_en, wr2_en, addr_wr1, addr_wr2);
        end
        for (int i = 0; i < 40 && !(cmd_ready && !busy); i++) begin
            @(negedge clock);
            n++;
            en_cnt += int'(wr1_en) + int'(wr2_en);
        end
        tests++;
        if (n !== n_exp || en_cnt !== 0) begin
            fails++;
            $display("FAIL edge_rest: cycles=%0d enables=%0d, want %0d 0", n, en_cnt, n_exp);
        end
        @(negedge clock);
        tests++;
        if (wr1_en !== 1'b0 || wr2_en !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL edge_idle: en=%b%b busy=%b, want 00 0", wr1_en, wr2_en, busy);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        issue(0, 0, 20, 20, 4'h9);
        repeat (4) @(negedge clock);
        tests++;
        if (wr1_en !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midrst_running: wr1_en=%b busy=%b, want 1 1", wr1_en, busy);
        end
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if ({cmd_ready, busy, wr1_en, wr2_en, addr_wr1, addr_wr2, data_wr1, data_wr2} !== '0) begin
            fails++;
            $display("FAIL midrst_zero: ready=%b busy=%b en=%b%b a=%0d/%0d d=%h/%h, want all 0",
                     cmd_ready, busy, wr1_en, wr2_en, addr_wr1, addr_wr2, data_wr1, data_wr2);
        end
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_ready: ready=%b, want 1", cmd_ready);
        end
        repeat (6) begin
            @(negedge clock);
            bad += int'(wr1_en) + int'(wr2_en) + int'(busy);
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL midrst_quiet: strobe/busy cycles=%0d, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_width();
        test_empty();
        test_vsync_stall();
        test_edge_clip();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
